// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
// pacman_pkg: shared map geometry, tile codes and the arbiter return-slot type
// Revision: 1.0
// ============================================================================
package pacman_pkg;

  localparam int MAP_W     = 48;
  localparam int MAP_H     = 27;
  localparam int MAP_SIZE  = MAP_W * MAP_H;
  localparam int TILE_W    = 40;
  localparam int TILE_H    = 40;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 4;
  localparam int RET_IDX_W = 3;

  typedef enum logic [DATA_W-1:0] {
    TILE_BG   = 4'd0,
    TILE_WALL = 4'd1,
    TILE_COIN = 4'd2
  } tile_code_t;

  typedef struct packed {
    logic                 valid;
    logic [RET_IDX_W-1:0] idx;
    logic                 oor;
  } ret_slot_t;

  // Modular increment that also wraps for non-power-of-2 moduli.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick: combinational round-robin picker, first set req bit at/after ptr
// Revision: 1.0
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 6,
  parameter int PTR_W = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W:0] w_cand;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (w_cand >= (PTR_W+1)'(N_REQ)) begin
        w_cand = w_cand - (PTR_W+1)'(N_REQ);
      end
      if (!any && req[w_cand[PTR_W-1:0]]) begin
        any                     = 1'b1;
        gnt[w_cand[PTR_W-1:0]] = 1'b1;
        idx                     = w_cand[PTR_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tile_rom_arbiter.sv
`default_nettype none
// ============================================================================
// tile_rom_arbiter: shares one synchronous tile-map ROM port among requesters
// Revision: 1.0
// ============================================================================
module tile_rom_arbiter
  import pacman_pkg::*;
#(
  parameter int                N_REQ    = 6,
  parameter int                ADDR_W   = pacman_pkg::ADDR_W,
  parameter int                DATA_W   = pacman_pkg::DATA_W,
  parameter int                MAP_SIZE = pacman_pkg::MAP_SIZE,
  parameter int                ROM_LAT  = 1,
  parameter int                PRIO0    = 0,
  parameter logic [DATA_W-1:0] OOR_CODE = DATA_W'(pacman_pkg::TILE_WALL)
) (
  input  logic                    clk_pix,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [3:0]              busy_cnt
);

  localparam int                PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W:0]   c_map_lim = (ADDR_W+1)'(MAP_SIZE);

  logic [PTR_W-1:0]  r_rr_ptr;
  logic [N_REQ-1:0]  w_pick_gnt;
  logic [PTR_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_prio;
  logic              w_grant_vld;
  logic [PTR_W-1:0]  w_win_idx;
  logic [ADDR_W-1:0] w_win_addr;
  logic              w_oor;
  ret_slot_t         w_slot_in;
  ret_slot_t         w_last;
  ret_slot_t         r_pipe [ROM_LAT];
  logic [DATA_W-1:0] w_ret_data;
  logic [DATA_W-1:0] r_rd_hold;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (req),
    .ptr (r_rr_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  assign w_prio      = (PRIO0 != 0) && req[0];
  assign w_win_idx   = w_prio ? '0 : w_pick_idx;
  assign w_grant_vld = rstn && w_pick_any;

  always_comb begin
    w_win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win_idx == PTR_W'(i)) begin
        w_win_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_oor = ({1'b0, w_win_addr} >= c_map_lim);

  always_comb begin
    gnt = '0;
    if (w_grant_vld) begin
      gnt = w_prio ? N_REQ'(1) : w_pick_gnt;
    end
  end

  // Out-of-range reads still take a grant slot but never touch the ROM.
  assign rom_en   = w_grant_vld && !w_oor;
  assign rom_addr = rom_en ? w_win_addr : '0;
  assign busy_cnt = rstn ? 4'($countones(req)) : 4'd0;

  always_ff @(posedge clk_pix) begin
    if (!rstn) begin
      r_rr_ptr <= '0;
    end else if (w_pick_any && !w_prio) begin
      r_rr_ptr <= PTR_W'(wrap_inc(int'(w_pick_idx), N_REQ));
    end
  end

  assign w_slot_in.valid = w_grant_vld;
  assign w_slot_in.idx   = RET_IDX_W'(w_win_idx);
  assign w_slot_in.oor   = w_oor;

  always_ff @(posedge clk_pix) begin
    if (!rstn) begin
      for (int s = 0; s < ROM_LAT; s++) begin
        r_pipe[s] <= '0;
      end
    end else begin
      r_pipe[0] <= w_slot_in;
      for (int s = 1; s < ROM_LAT; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
    end
  end

  assign w_last     = r_pipe[ROM_LAT-1];
  assign w_ret_data = w_last.oor ? OOR_CODE : rom_data;

  for (genvar i = 0; i < N_REQ; i++) begin : g_rd_valid
    assign rd_valid[i] = w_last.valid && (w_last.idx == RET_IDX_W'(i));
  end

  // ROM data is only meaningful in the return cycle; hold it afterwards.
  always_ff @(posedge clk_pix) begin
    if (!rstn) begin
      r_rd_hold <= '0;
    end else if (w_last.valid) begin
      r_rd_hold <= w_ret_data;
    end
  end

  assign rd_data = w_last.valid ? w_ret_data : r_rd_hold;

endmodule
`default_nettype wire

// File: tb/tb_tile_rom_arbiter.sv
`default_nettype none
// ============================================================================
// tb_tile_rom_arbiter: table vectors, directed corner sequences, random + model
// Revision: 1.0
// ============================================================================
module tb_tile_rom_arbiter;

  logic        clk_pix = 1'b0;
  logic        rstn;
  logic [5:0]  req;
  logic [65:0] req_addr;
  logic [4:0]  req_c;
  logic [54:0] req_addr_c;

  logic [5:0]  gnt_a, rdv_a, gnt_b, rdv_b;
  logic [4:0]  gnt_c, rdv_c;
  logic [3:0]  rdd_a, rdd_b, rdd_c, busy_a, busy_b, busy_c;
  logic        rom_en_a, rom_en_b, rom_en_c;
  logic [10:0] rom_addr_a, rom_addr_b, rom_addr_c;
  logic [3:0]  rom_q_a = '0, rom_s1_b = '0, rom_q_b = '0, rom_q_c = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_pix = ~clk_pix;

  tile_rom_arbiter dut_a (
    .clk_pix(clk_pix), .rstn(rstn), .req(req), .req_addr(req_addr),
    .gnt(gnt_a), .rd_valid(rdv_a), .rd_data(rdd_a), .rom_en(rom_en_a),
    .rom_addr(rom_addr_a), .rom_data(rom_q_a), .busy_cnt(busy_a));

  tile_rom_arbiter #(.ROM_LAT(2), .PRIO0(1)) dut_b (
    .clk_pix(clk_pix), .rstn(rstn), .req(req), .req_addr(req_addr),
    .gnt(gnt_b), .rd_valid(rdv_b), .rd_data(rdd_b), .rom_en(rom_en_b),
    .rom_addr(rom_addr_b), .rom_data(rom_q_b), .busy_cnt(busy_b));

  tile_rom_arbiter #(.N_REQ(5)) dut_c (
    .clk_pix(clk_pix), .rstn(rstn), .req(req_c), .req_addr(req_addr_c),
    .gnt(gnt_c), .rd_valid(rdv_c), .rd_data(rdd_c), .rom_en(rom_en_c),
    .rom_addr(rom_addr_c), .rom_data(rom_q_c), .busy_cnt(busy_c));

  function automatic logic [3:0] romf(input logic [10:0] a);
    return 4'(a % 11'd7);
  endfunction

  // Synchronous ROM stand-ins; output holds while enable is low.
  always @(posedge clk_pix) begin
    if (rom_en_a) rom_q_a <= romf(rom_addr_a);
    if (rom_en_b) rom_s1_b <= romf(rom_addr_b);
    rom_q_b <= rom_s1_b;
    if (rom_en_c) rom_q_c <= romf(rom_addr_c);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model for dut_a: scan-from-pointer arbitration and a queue of
  // expected returns, each due one cycle after its grant.
  typedef struct { int due; int idx; logic [3:0] data; } ret_t;
  ret_t       m_q[$];
  int         m_ptr = 0;
  int         m_cyc = 0;
  logic [3:0] m_last = '0;
  bit         m_en = 1'b0;

  task automatic model_step();
    int          w;
    logic [10:0] a;
    logic [5:0]  ev;
    logic [3:0]  ed;
    if (!rstn) begin
      chk("m_gnt_rst", gnt_a, 0);
      chk("m_en_rst", rom_en_a, 0);
      chk("m_busy_rst", busy_a, 0);
      m_q.delete();
      m_ptr = 0; m_last = '0; m_cyc++;
      return;
    end
    ev = '0; ed = m_last;
    if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
      ev = 6'(1 << m_q[0].idx);
      ed = m_q[0].data;
      m_last = ed;
      void'(m_q.pop_front());
    end
    chk("m_rd_valid", rdv_a, ev);
    chk("m_rd_data", rdd_a, ed);
    chk("m_busy", busy_a, $countones(req));
    w = -1;
    for (int k = 0; k < 6; k++) begin
      int j = (m_ptr + k) % 6;
      if (w < 0 && req[j]) w = j;
    end
    if (w < 0) begin
      chk("m_gnt_idle", gnt_a, 0);
      chk("m_en_idle", rom_en_a, 0);
    end else begin
      a = req_addr[w*11 +: 11];
      chk("m_gnt", gnt_a, 32'(1) << w);
      if (a < 11'd1296) begin
        chk("m_en", rom_en_a, 1);
        chk("m_rom_addr", rom_addr_a, a);
        m_q.push_back('{m_cyc + 1, w, romf(a)});
      end else begin
        chk("m_en_oor", rom_en_a, 0);
        chk("m_rom_addr_oor", rom_addr_a, 0);
        m_q.push_back('{m_cyc + 1, w, 4'd1});
      end
      m_ptr = (w + 1) % 6;
    end
    m_cyc++;
  endtask

  always @(negedge clk_pix) if (m_en) model_step();

  typedef struct {
    logic [5:0]  req;
    logic [10:0] addr;
    logic [5:0]  gnt;
    logic        en;
    logic [10:0] raddr;
    logic [3:0]  busy;
    logic [5:0]  rdv;
    logic [3:0]  rdd;
  } vec_t;
  vec_t tbl [10];

  task automatic do_reset();
    @(posedge clk_pix); #1;
    rstn = 1'b0; req = '1; req_c = '1;
    @(negedge clk_pix);
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_gnt_c", gnt_c, 0);
    chk("rst_rom_en", rom_en_a, 0);
    chk("rst_busy", busy_a, 0);
    @(posedge clk_pix); #1;
    rstn = 1'b1; req = '0; req_c = '0;
    @(negedge clk_pix);
    chk("rst_rdv_a", rdv_a, 0);
    chk("rst_rdd_a", rdd_a, 0);
  endtask

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : stim
    int cnt [6];
    rstn = 1'b0; req = '0; req_addr = '0; req_c = '0; req_addr_c = '0;
    m_en = 1'b1;

    tbl[0] = '{6'b000100, 11'd100,  6'b000100, 1'b1, 11'd100,  4'd1, 6'b000000, 4'd0};
    tbl[1] = '{6'b000000, 11'd0,    6'b000000, 1'b0, 11'd0,    4'd0, 6'b000100, 4'd2};
    tbl[2] = '{6'b000100, 11'd1296, 6'b000100, 1'b0, 11'd0,    4'd1, 6'b000000, 4'd2};
    tbl[3] = '{6'b000000, 11'd0,    6'b000000, 1'b0, 11'd0,    4'd0, 6'b000100, 4'd1};
    tbl[4] = '{6'b000100, 11'd1295, 6'b000100, 1'b1, 11'd1295, 4'd1, 6'b000000, 4'd1};
    tbl[5] = '{6'b000000, 11'd0,    6'b000000, 1'b0, 11'd0,    4'd0, 6'b000100, 4'd0};
    tbl[6] = '{6'b100001, 11'd50,   6'b100000, 1'b1, 11'd50,   4'd2, 6'b000000, 4'd0};
    tbl[7] = '{6'b100001, 11'd51,   6'b000001, 1'b1, 11'd51,   4'd2, 6'b100000, 4'd1};
    tbl[8] = '{6'b100001, 11'd52,   6'b100000, 1'b1, 11'd52,   4'd2, 6'b000001, 4'd2};
    tbl[9] = '{6'b000000, 11'd0,    6'b000000, 1'b0, 11'd0,    4'd0, 6'b100000, 4'd3};

    do_reset();
    for (int r = 0; r < 10; r++) begin
      @(posedge clk_pix); #1;
      req = tbl[r].req; req_addr = {6{tbl[r].addr}};
      @(negedge clk_pix);
      chk($sformatf("tbl%0d_gnt", r), gnt_a, tbl[r].gnt);
      chk($sformatf("tbl%0d_rom_en", r), rom_en_a, tbl[r].en);
      chk($sformatf("tbl%0d_rom_addr", r), rom_addr_a, tbl[r].raddr);
      chk($sformatf("tbl%0d_busy", r), busy_a, tbl[r].busy);
      chk($sformatf("tbl%0d_rd_valid", r), rdv_a, tbl[r].rdv);
      chk($sformatf("tbl%0d_rd_data", r), rdd_a, tbl[r].rdd);
    end

    // All six requesters held: strict rotation, two returns each.
    do_reset();
    for (int i = 0; i < 6; i++) cnt[i] = 0;
    for (int k = 0; k < 13; k++) begin
      @(posedge clk_pix); #1;
      req = (k < 12) ? 6'b111111 : 6'b000000;
      for (int i = 0; i < 6; i++) req_addr[i*11 +: 11] = 11'($urandom_range(0, 1295));
      @(negedge clk_pix);
      if (k < 12) begin
        chk($sformatf("rot%0d_gnt_a", k), gnt_a, 32'(1) << (k % 6));
        chk($sformatf("rot%0d_gnt_b", k), gnt_b, 1);
      end
      for (int i = 0; i < 6; i++) if (rdv_a[i]) cnt[i]++;
    end
    for (int i = 0; i < 6; i++) chk($sformatf("rot_rdv_count%0d", i), cnt[i], 2);

    // Requesters 0 and 3: alternation without priority, starvation with it.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_pix); #1;
      req = 6'b001001; req_addr = '0;
      req_addr[0 +: 11] = 11'd30; req_addr[33 +: 11] = 11'd40;
      @(negedge clk_pix);
      chk($sformatf("prio%0d_gnt_a", k), gnt_a, (k % 2 == 0) ? 1 : 8);
      chk($sformatf("prio%0d_gnt_b", k), gnt_b, 1);
      chk($sformatf("prio%0d_rdv_b", k), rdv_b, (k >= 2) ? 1 : 0);
      if (k >= 2) chk($sformatf("prio%0d_rdd_b", k), rdd_b, 2);
    end

    // Reset while a ROM_LAT=2 read is in flight.
    do_reset();
    @(posedge clk_pix); #1;
    req = 6'b000010; req_addr = {6{11'd10}};
    @(negedge clk_pix);
    chk("mid_gnt_b", gnt_b, 2);
    @(posedge clk_pix); #1;
    rstn = 1'b0; req = '0;
    @(negedge clk_pix);
    chk("mid_rdv_b_rst", rdv_b, 0);
    @(posedge clk_pix); #1;
    rstn = 1'b1;
    @(negedge clk_pix);
    chk("mid_rdv_b_after", rdv_b, 0);
    chk("mid_rdd_b_after", rdd_b, 0);
    @(posedge clk_pix); #1;
    req = 6'b100001;
    @(negedge clk_pix);
    chk("mid_first_gnt_a", gnt_a, 1);
    chk("mid_first_gnt_b", gnt_b, 1);
    chk("mid_rdv_b_late", rdv_b, 0);
    @(posedge clk_pix); #1;
    @(negedge clk_pix);
    chk("mid_second_gnt_a", gnt_a, 32);
    @(posedge clk_pix); #1;
    req = '0;

    // Five requesters: pointer wrap from 4 back to 0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_pix); #1;
      req_c = 5'b10001; req_addr_c = {5{11'd20}};
      @(negedge clk_pix);
      chk($sformatf("wrap%0d_gnt_c", k), gnt_c, (k % 2 == 0) ? 1 : 16);
      if (k == 0) chk("wrap_busy_c", busy_c, 2);
      if (k == 1) begin
        chk("wrap_rdv_c", rdv_c, 1);
        chk("wrap_rdd_c", rdd_c, 6);
      end
      if (k == 2) chk("wrap_rdv_c2", rdv_c, 16);
    end

    // Randomized traffic with occasional reset, checked by the model.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk_pix); #1;
      rstn = ($urandom_range(0, 49) != 0);
      req = 6'($urandom);
      req_c = 5'($urandom);
      for (int i = 0; i < 6; i++) req_addr[i*11 +: 11] = 11'($urandom_range(0, 1350));
      req_addr_c = {5{11'($urandom_range(0, 1350))}};
    end
    @(posedge clk_pix); #1;
    rstn = 1'b1; req = '0; req_c = '0;
    repeat (3) @(posedge clk_pix);
    #1;
    m_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
